mem_resp_stage: RTL and testbench

Pipeline stage between the memory-request stage (RS) and write-back (WS). It holds one instruction at a time and waits for `data_sram_data_ok` on loads and stores. A response that arrives while WS is stalled is parked in a one-entry buffer. Load data is aligned and extended for LB/LBU/LH/LHU/LW and merged with the old rt value for LWL/LWR. The block also drives the bypass bundle for the decode stage.

---
 rtl/mem_resp_stage.sv | 124 ++++++++++++
 tb/tb_mem_resp_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_resp_stage.sv
// Memory-response pipeline stage: waits for data_ok on loads/stores, parks a
// response while WS is stalled, aligns load data and drives the decode bypass.
module mem_resp_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         ws_allowin,
    output logic         ms_allowin,
    input  logic         rs_to_ms_valid,
    input  logic [114:0] rs_to_ms_bus,
    input  logic         data_sram_data_ok,
    input  logic [31:0]  data_sram_rdata,
    output logic         ms_to_ws_valid,
    output logic [72:0]  ms_to_ws_bus,
    output logic [42:0]  ms_reg
);
    localparam int unsigned RS_TO_MS_BUS_WD = 115;

    logic                       ms_valid_q, ms_valid_d;
    logic [RS_TO_MS_BUS_WD-1:0] ms_bus_q, ms_bus_d;
    logic                       buf_valid_q, buf_valid_d;
    logic [31:0]                buf_data_q, buf_data_d;

    logic [1:0]  addr_lo;
    logic        inst_mfc0;
    logic [31:0] c0_rdata;
    logic        is_load, is_store;
    logic [6:0]  load_op;
    logic        res_from_mem, gr_we;
    logic [4:0]  dest;
    logic [31:0] result, pc;

    assign {addr_lo, inst_mfc0, c0_rdata, is_load, is_store, load_op,
            res_from_mem, gr_we, dest, result, pc} = ms_bus_q;

    logic        mem_op, ms_ready_go, ms_load_pending;
    logic [31:0] mem_data, load_data, final_result;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [3:0]  rf_we;

    assign mem_op          = is_load | is_store;
    assign ms_ready_go     = !mem_op | data_sram_data_ok | buf_valid_q;
    assign ms_allowin      = !ms_valid_q | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid  = ms_valid_q & ms_ready_go;
    assign ms_load_pending = ms_valid_q & is_load & !ms_ready_go;
    assign mem_data        = buf_valid_q ? buf_data_q : data_sram_rdata;

    always_comb begin
        case (addr_lo)
            2'd0:    sel_byte = mem_data[7:0];
            2'd1:    sel_byte = mem_data[15:8];
            2'd2:    sel_byte = mem_data[23:16];
            default: sel_byte = mem_data[31:24];
        endcase
        sel_half = addr_lo[1] ? mem_data[31:16] : mem_data[15:0];
    end

    // Unaligned LWL/LWR merge the fetched bytes into the forwarded old rt (result)
    always_comb begin
        load_data = mem_data;
        if (load_op[0]) begin
            load_data = {{24{sel_byte[7]}}, sel_byte};
        end else if (load_op[1]) begin
            load_data = {24'd0, sel_byte};
        end else if (load_op[2]) begin
            load_data = {{16{sel_half[15]}}, sel_half};
        end else if (load_op[3]) begin
            load_data = {16'd0, sel_half};
        end else if (load_op[5]) begin
            case (addr_lo)
                2'd0:    load_data = {mem_data[7:0],  result[23:0]};
                2'd1:    load_data = {mem_data[15:0], result[15:0]};
                2'd2:    load_data = {mem_data[23:0], result[7:0]};
                default: load_data = mem_data;
            endcase
        end else if (load_op[6]) begin
            case (addr_lo)
                2'd0:    load_data = mem_data;
                2'd1:    load_data = {result[31:24], mem_data[31:8]};
                2'd2:    load_data = {result[31:16], mem_data[31:16]};
                default: load_data = {result[31:8],  mem_data[31:24]};
            endcase
        end
    end

    assign final_result = res_from_mem ? load_data : (inst_mfc0 ? c0_rdata : result);
    assign rf_we        = {4{gr_we & ms_valid_q}};
    assign ms_to_ws_bus = {rf_we, dest, final_result, pc};
    assign ms_reg       = {rf_we, ms_load_pending, ms_valid_q & inst_mfc0,
                           dest & {5{ms_valid_q}}, final_result & {32{ms_valid_q}}};

    always_comb begin
        ms_valid_d  = ms_valid_q;
        ms_bus_d    = ms_bus_q;
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        if (ms_allowin) begin
            ms_valid_d = rs_to_ms_valid;
        end
        if (rs_to_ms_valid && ms_allowin) begin
            ms_bus_d = rs_to_ms_bus;
        end
        if (ms_valid_q && mem_op && data_sram_data_ok && !ws_allowin) begin
            buf_valid_d = 1'b1;
            buf_data_d  = data_sram_rdata;
        end else if (ms_to_ws_valid && ws_allowin) begin
            buf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q  <= 1'b0;
            ms_bus_q    <= '0;
            buf_valid_q <= 1'b0;
            buf_data_q  <= '0;
        end else begin
            ms_valid_q  <= ms_valid_d;
            ms_bus_q    <= ms_bus_d;
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
        end
    end
endmodule

// File: tb/tb_mem_resp_stage.sv
// Directed self-checking bench for mem_resp_stage.
module tb_mem_resp_stage;
    logic         clk = 1'b0;
    logic         reset;
    logic         ws_allowin;
    logic         ms_allowin;
    logic         rs_to_ms_valid;
    logic [114:0] rs_to_ms_bus;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         ms_to_ws_valid;
    logic [72:0]  ms_to_ws_bus;
    logic [42:0]  ms_reg;

    int checks   = 0;
    int failures = 0;

    mem_resp_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .rs_to_ms_valid    (rs_to_ms_valid),
        .rs_to_ms_bus      (rs_to_ms_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_reg            (ms_reg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [114:0] mk(input logic [1:0] k, input logic mfc0,
                                        input logic [31:0] c0, input logic ld,
                                        input logic st, input logic [6:0] lop,
                                        input logic rfm, input logic gwe,
                                        input logic [4:0] dst, input logic [31:0] res,
                                        input logic [31:0] pc);
        return {k, mfc0, c0, ld, st, lop, rfm, gwe, dst, res, pc};
    endfunction

    // Enter a load, hold data_ok off for 'waits' cycles, then deliver rdata.
    task automatic run_load(input string tag, input logic [114:0] bus, input int waits,
                            input logic [31:0] rdata, input logic [31:0] exp);
        rs_to_ms_valid = 1'b1;
        rs_to_ms_bus   = bus;
        cyc();
        rs_to_ms_valid = 1'b0;
        for (int i = 0; i < waits; i++) begin
            #1;
            check({tag, "_pending"}, 64'(ms_reg[38]), 64'd1);
            check({tag, "_notvalid"}, 64'(ms_to_ws_valid), 64'd0);
            cyc();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rdata;
        #1;
        check({tag, "_valid"}, 64'(ms_to_ws_valid), 64'd1);
        check({tag, "_result"}, 64'(ms_to_ws_bus[63:32]), 64'(exp));
        cyc();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
    endtask

    localparam logic [6:0] OP_LB = 7'b0000001, OP_LBU = 7'b0000010, OP_LH = 7'b0000100,
                           OP_LHU = 7'b0001000, OP_LW = 7'b0010000, OP_LWL = 7'b0100000,
                           OP_LWR = 7'b1000000;

    initial begin
        reset = 1'b1;
        ws_allowin = 1'b1;
        rs_to_ms_valid = 1'b0;
        rs_to_ms_bus = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = '0;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        check("rst_allowin", 64'(ms_allowin), 64'd1);
        check("rst_valid", 64'(ms_to_ws_valid), 64'd0);
        check("rst_ms_reg", 64'(ms_reg), 64'd0);
        check("rst_buf", 64'(dut.buf_valid_q), 64'd0);

        // ADDU: one cycle through
        rs_to_ms_valid = 1'b1;
        rs_to_ms_bus = mk(2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'h100);
        cyc();
        rs_to_ms_valid = 1'b0;
        #1;
        check("addu_valid", 64'(ms_to_ws_valid), 64'd1);
        check("addu_result", 64'(ms_to_ws_bus[63:32]), 64'h1234);
        check("addu_rfwe", 64'(ms_to_ws_bus[72:69]), 64'hF);
        check("addu_dest", 64'(ms_to_ws_bus[68:64]), 64'd5);
        check("addu_pc", 64'(ms_to_ws_bus[31:0]), 64'h100);
        check("addu_ms_reg", 64'(ms_reg), 64'({4'hF, 1'b0, 1'b0, 5'd5, 32'h1234}));
        cyc();
        check("addu_gone", 64'(ms_to_ws_valid), 64'd0);

        // Sub-word loads
        run_load("lb",  mk(2'd2, 1'b0, 32'h0, 1'b1, 1'b0, OP_LB,  1'b1, 1'b1, 5'd3, 32'h0, 32'h200),
                 3, 32'h0080_0000, 32'hFFFF_FF80);
        run_load("lbu", mk(2'd2, 1'b0, 32'h0, 1'b1, 1'b0, OP_LBU, 1'b1, 1'b1, 5'd3, 32'h0, 32'h204),
                 1, 32'h0080_0000, 32'h0000_0080);
        run_load("lb1", mk(2'd1, 1'b0, 32'h0, 1'b1, 1'b0, OP_LB,  1'b1, 1'b1, 5'd3, 32'h0, 32'h208),
                 0, 32'h8001_7F00, 32'h0000_007F);
        run_load("lh",  mk(2'd2, 1'b0, 32'h0, 1'b1, 1'b0, OP_LH,  1'b1, 1'b1, 5'd3, 32'h0, 32'h20C),
                 1, 32'h8001_7F00, 32'hFFFF_8001);
        run_load("lhu", mk(2'd0, 1'b0, 32'h0, 1'b1, 1'b0, OP_LHU, 1'b1, 1'b1, 5'd3, 32'h0, 32'h210),
                 1, 32'h8001_8F00, 32'h0000_8F00);
        run_load("lwl", mk(2'd1, 1'b0, 32'h0, 1'b1, 1'b0, OP_LWL, 1'b1, 1'b1, 5'd3, 32'h1122_3344, 32'h214),
                 1, 32'hAABB_CCDD, 32'hCCDD_3344);
        run_load("lwr", mk(2'd1, 1'b0, 32'h0, 1'b1, 1'b0, OP_LWR, 1'b1, 1'b1, 5'd3, 32'h1122_3344, 32'h218),
                 1, 32'hAABB_CCDD, 32'h11AA_BBCC);
        run_load("lwl3", mk(2'd3, 1'b0, 32'h0, 1'b1, 1'b0, OP_LWL, 1'b1, 1'b1, 5'd3, 32'h1122_3344, 32'h21C),
                 1, 32'hAABB_CCDD, 32'hAABB_CCDD);
        run_load("lwr3", mk(2'd3, 1'b0, 32'h0, 1'b1, 1'b0, OP_LWR, 1'b1, 1'b1, 5'd3, 32'h1122_3344, 32'h220),
                 1, 32'hAABB_CCDD, 32'h1122_33AA);

        // LW with WS stalled: response parked in the buffer
        rs_to_ms_valid = 1'b1;
        rs_to_ms_bus = mk(2'd0, 1'b0, 32'h0, 1'b1, 1'b0, OP_LW, 1'b1, 1'b1, 5'd7, 32'h0, 32'h300);
        cyc();
        rs_to_ms_valid = 1'b0;
        ws_allowin = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hDEAD_BEEF;
        #1;
        check("lwbuf_valid", 64'(ms_to_ws_valid), 64'd1);
        check("lwbuf_allowin0", 64'(ms_allowin), 64'd0);
        cyc();
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'h1234_5678;
        #1;
        check("lwbuf_set", 64'(dut.buf_valid_q), 64'd1);
        check("lwbuf_hold1", 64'(ms_to_ws_bus[63:32]), 64'hDEAD_BEEF);
        check("lwbuf_pending", 64'(ms_reg[38]), 64'd0);
        cyc();
        check("lwbuf_hold2", 64'(ms_to_ws_bus[63:32]), 64'hDEAD_BEEF);
        check("lwbuf_allowin1", 64'(ms_allowin), 64'd0);
        ws_allowin = 1'b1;
        #1;
        check("lwbuf_exit_valid", 64'(ms_to_ws_valid), 64'd1);
        check("lwbuf_exit_allowin", 64'(ms_allowin), 64'd1);
        cyc();
        check("lwbuf_clear", 64'(dut.buf_valid_q), 64'd0);
        check("lwbuf_gone", 64'(ms_to_ws_valid), 64'd0);

        // SW then ADDU entering on the SW's exit cycle
        rs_to_ms_valid = 1'b1;
        rs_to_ms_bus = mk(2'd0, 1'b0, 32'h0, 1'b0, 1'b1, 7'd0, 1'b0, 1'b0, 5'd0, 32'h55, 32'h400);
        cyc();
        rs_to_ms_valid = 1'b0;
        #1;
        check("sw_wait_valid", 64'(ms_to_ws_valid), 64'd0);
        check("sw_no_pending", 64'(ms_reg[38]), 64'd0);
        cyc();
        data_sram_data_ok = 1'b1;
        rs_to_ms_valid = 1'b1;
        rs_to_ms_bus = mk(2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 5'd9, 32'h9999, 32'h404);
        #1;
        check("sw_exit_valid", 64'(ms_to_ws_valid), 64'd1);
        check("sw_rfwe", 64'(ms_to_ws_bus[72:69]), 64'h0);
        check("sw_allowin", 64'(ms_allowin), 64'd1);
        cyc();
        data_sram_data_ok = 1'b0;
        rs_to_ms_valid = 1'b0;
        #1;
        check("addu2_valid", 64'(ms_to_ws_valid), 64'd1);
        check("addu2_result", 64'(ms_to_ws_bus[63:32]), 64'h9999);
        check("addu2_pc", 64'(ms_to_ws_bus[31:0]), 64'h404);
        cyc();
        check("addu2_gone", 64'(ms_to_ws_valid), 64'd0);

        // MFC0 selects c0_rdata
        rs_to_ms_valid = 1'b1;
        rs_to_ms_bus = mk(2'd0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 5'd12, 32'h1, 32'h500);
        cyc();
        rs_to_ms_valid = 1'b0;
        #1;
        check("mfc0_result", 64'(ms_to_ws_bus[63:32]), 64'hCAFE_F00D);
        check("mfc0_flag", 64'(ms_reg[37]), 64'd1);
        check("mfc0_dest", 64'(ms_reg[36:32]), 64'd12);
        cyc();

        // Reset while an LW holds a buffered response
        rs_to_ms_valid = 1'b1;
        rs_to_ms_bus = mk(2'd0, 1'b0, 32'h0, 1'b1, 1'b0, OP_LW, 1'b1, 1'b1, 5'd4, 32'h0, 32'h600);
        cyc();
        rs_to_ms_valid = 1'b0;
        ws_allowin = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h0BAD_F00D;
        cyc();
        data_sram_data_ok = 1'b0;
        check("rstw_buf_set", 64'(dut.buf_valid_q), 64'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        ws_allowin = 1'b1;
        #1;
        check("rstw_valid", 64'(ms_to_ws_valid), 64'd0);
        check("rstw_buf", 64'(dut.buf_valid_q), 64'd0);
        check("rstw_allowin", 64'(ms_allowin), 64'd1);
        check("rstw_ms_reg", 64'(ms_reg), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
